// File: rtl/yuv422_to_420_pack.sv
// Converts a YUYV 4:2:2 camera byte stream to 4:2:0 by keeping all bytes on even
// lines and only Y bytes on odd lines, buffering the result in a small byte FIFO.
module yuv422_to_420_pack #(
  parameter int LINE_PIXELS = 1280,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_de,
  input  logic [7:0] cam_data,
  output logic [7:0] data_o,
  output logic       w_valid,
  input  logic       w_ready,
  output logic       frame_start,
  output logic       line_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [11:0] LINE_BYTES = 12'(2 * LINE_PIXELS);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LINE = 2'd1;
  localparam logic [1:0] LINE      = 2'd2;
  localparam logic [1:0] LINE_END  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        vsync_q;
  logic        parity;
  logic [11:0] byte_cnt;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        vs_fall;
  logic        vs_rise;
  logic        byte_valid;
  logic        push_req;
  logic        pop;
  logic        full;
  logic        empty;
  logic        do_push;

  assign vs_fall    = vsync_q & ~cam_vsync;
  assign vs_rise    = ~vsync_q & cam_vsync;
  assign byte_valid = cam_href & cam_de;
  // Odd lines keep only even byte positions (the Y samples).
  assign push_req   = (state == LINE) & byte_valid & (~parity | ~byte_cnt[0]) & ~vs_rise;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & w_ready;
  assign do_push = push_req & (~full | pop);
  assign w_valid = ~empty;
  assign data_o  = mem[rd_ptr[AW-1:0]];

  // Next-state decode; a vsync rise aborts to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (vs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (vs_fall)   state_nxt = WAIT_LINE; else state_nxt = IDLE;
        WAIT_LINE: if (cam_href)  state_nxt = LINE;      else state_nxt = WAIT_LINE;
        LINE:      if (!cam_href) state_nxt = LINE_END;  else state_nxt = LINE;
        LINE_END:  state_nxt = WAIT_LINE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Control state, line bookkeeping and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      parity      <= 1'b0;
      byte_cnt    <= 12'd0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      vsync_q     <= cam_vsync;
      frame_start <= (state == IDLE) & vs_fall;
      line_err    <= (state == LINE_END) & (byte_cnt != LINE_BYTES) & ~vs_rise;
      if (vs_rise) begin
        parity   <= 1'b0;
        byte_cnt <= 12'd0;
      end else if (state == LINE_END) begin
        parity   <= ~parity;
        byte_cnt <= 12'd0;
      end else if ((state == LINE) && byte_valid && (byte_cnt != 12'hFFF)) begin
        byte_cnt <= byte_cnt + 12'd1;
      end
      if ((state == IDLE) && vs_fall) begin
        overflow <= 1'b0;
      end else if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers wrap naturally over 2*FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)     rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= cam_data;
  end

endmodule

// File: tb/tb_yuv422_to_420_pack.sv
// Scoreboard bench for yuv422_to_420_pack with 4-pixel lines and a 16-byte FIFO.
module tb_yuv422_to_420_pack;

  localparam int LINE_PIXELS = 4;
  localparam int FIFO_DEPTH  = 16;

  logic       clk;
  logic       rst_n;
  logic       cam_vsync;
  logic       cam_href;
  logic       cam_de;
  logic [7:0] cam_data;
  logic [7:0] data_o;
  logic       w_valid;
  logic       w_ready;
  logic       frame_start;
  logic       line_err;
  logic       overflow;

  yuv422_to_420_pack #(.LINE_PIXELS(LINE_PIXELS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_de(cam_de), .cam_data(cam_data), .data_o(data_o), .w_valid(w_valid),
    .w_ready(w_ready), .frame_start(frame_start), .line_err(line_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         fs_pulses = 0;
  int         err_pulses = 0;
  logic [7:0] sb[$];
  bit         exp_fs = 1'b0;
  bit         exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs, drive inputs, then pop/push the scoreboard for the coming edge.
  task automatic cycle(input bit vs, input bit hr, input bit de, input logic [7:0] d,
                       input bit rdy, input bit keep);
    @(negedge clk);
    check("w_valid", 32'(w_valid), 32'(sb.size() != 0));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (frame_start) fs_pulses++;
    if (line_err) err_pulses++;
    exp_fs = 1'b0;
    if (cam_vsync && !vs) begin
      exp_fs  = 1'b1;
      exp_ovf = 1'b0;
    end
    cam_vsync = vs;
    cam_href  = hr;
    cam_de    = de;
    cam_data  = d;
    w_ready   = rdy;
    if (sb.size() != 0 && rdy) begin
      check("data_o", 32'(data_o), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (keep) begin
      if (sb.size() < FIFO_DEPTH) sb.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic vsync_fall();
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic send_line(input logic [7:0] base, input int n, input bit odd,
                           input bit rdy, input bit en);
    logic [7:0] b;
    cycle(1'b0, 1'b1, 1'b0, 8'h00, rdy, 1'b0);
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      cycle(1'b0, 1'b1, 1'b1, b, rdy, en && (!odd || (i % 2 == 0)));
    end
    idle(3, rdy);
  endtask

  int fs0;
  int e0;
  logic [7:0] b;

  initial begin
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_de = 1'b0;
    cam_data = 8'h00; w_ready = 1'b1;
    #3;
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Basic frame: even line kept whole, odd line keeps Y only.
    fs0 = fs_pulses; e0 = err_pulses;
    vsync_fall();
    send_line(8'h10, 8, 1'b0, 1'b1, 1'b1);
    send_line(8'h20, 8, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("a_frame_start_cnt", 32'(fs_pulses - fs0), 32'd1);
    check("a_line_err_cnt", 32'(err_pulses - e0), 32'd0);

    // Short odd line flags an error; next line is still even.
    e0 = err_pulses;
    vsync_fall();
    send_line(8'h30, 8, 1'b0, 1'b1, 1'b1);
    send_line(8'h40, 7, 1'b1, 1'b1, 1'b1);
    send_line(8'h50, 8, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("b_line_err_cnt", 32'(err_pulses - e0), 32'd1);

    // Backpressure overflow on a 20-byte line, then drain.
    e0 = err_pulses;
    vsync_fall();
    send_line(8'h60, 20, 1'b0, 1'b0, 1'b1);
    idle(20, 1'b1);
    check("c_overflow_held", 32'(overflow), 32'd1);
    check("c_line_err_cnt", 32'(err_pulses - e0), 32'd1);

    // Full FIFO with simultaneous pop and push drops nothing.
    e0 = err_pulses;
    vsync_fall();
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      b = 8'h70 + 8'(i);
      cycle(1'b0, 1'b1, 1'b1, b, i >= 16, 1'b1);
    end
    idle(20, 1'b1);
    check("d_overflow_clear", 32'(overflow), 32'd0);
    check("d_line_err_cnt", 32'(err_pulses - e0), 32'd1);

    // vsync rise mid odd line; next frame starts even.
    fs0 = fs_pulses; e0 = err_pulses;
    vsync_fall();
    send_line(8'h80, 8, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b = 8'h88 + 8'(i);
      cycle(1'b0, 1'b1, 1'b1, b, 1'b1, (i % 2 == 0));
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vsync_fall();
    send_line(8'h90, 8, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("e_frame_start_cnt", 32'(fs_pulses - fs0), 32'd2);
    check("e_line_err_cnt", 32'(err_pulses - e0), 32'd0);

    // Reset mid-line: outputs drop at once, bytes ignored until next vsync fall.
    fs0 = fs_pulses; e0 = err_pulses;
    vsync_fall();
    w_ready = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b = 8'hA0 + 8'(i);
      cycle(1'b0, 1'b1, 1'b1, b, 1'b0, 1'b1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("f_rst_w_valid", 32'(w_valid), 32'd0);
    check("f_rst_frame_start", 32'(frame_start), 32'd0);
    check("f_rst_line_err", 32'(line_err), 32'd0);
    check("f_rst_overflow", 32'(overflow), 32'd0);
    sb.delete();
    exp_ovf = 1'b0;
    exp_fs  = 1'b0;
    idle(2, 1'b1);
    rst_n = 1'b1;
    send_line(8'hB0, 8, 1'b0, 1'b1, 1'b0);
    vsync_fall();
    send_line(8'hC0, 8, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("f_frame_start_cnt", 32'(fs_pulses - fs0), 32'd2);
    check("f_line_err_cnt", 32'(err_pulses - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/yuv422_to_420_pack.md
YUV422_TO_420_PACK -- requirements
Module: yuv422_to_420_pack

Interface
REQ-001 The block SHALL have parameter LINE_PIXELS, default 1280, giving the number of pixels per line (2*LINE_PIXELS bytes of YUYV per line).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the output FIFO depth in bytes (power of two, at least 4).
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port cam_vsync, input, 1 bit, the frame sync; high means vertical blanking.
REQ-006 The block SHALL have port cam_href, input, 1 bit, the line-active qualifier.
REQ-007 The block SHALL have port cam_de, input, 1 bit, the per-byte strobe; a byte is valid only when cam_href and cam_de are both 1.
REQ-008 The block SHALL have port cam_data, input, 8 bits, the camera byte in Y0 U0 Y1 V0 order.
REQ-009 The block SHALL have port data_o, output, 8 bits, the packed byte presented to the downstream YUV line buffer.
REQ-010 The block SHALL have port w_valid, output, 1 bit, high when data_o is valid.
REQ-011 The block SHALL have port w_ready, input, 1 bit, the downstream accept strobe.
REQ-012 The block SHALL have port frame_start, output, 1 bit, a one-cycle pulse at the start of each frame.
REQ-013 The block SHALL have port line_err, output, 1 bit, a one-cycle pulse when a short or long line is detected.
REQ-014 The block SHALL have port overflow, output, 1 bit, a sticky flag set when the FIFO drops a byte.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, WAIT_LINE, LINE and LINE_END.
REQ-016 IDLE SHALL go to WAIT_LINE on a cam_vsync falling edge (detected with a registered copy of cam_vsync), and SHALL pulse frame_start in that same cycle.
REQ-017 WAIT_LINE SHALL go to LINE on the first cycle with cam_href=1.
REQ-018 LINE SHALL go to LINE_END on the first cycle with cam_href=0.
REQ-019 LINE_END SHALL toggle line parity, clear the byte counter and return to WAIT_LINE, all in one cycle.
REQ-020 A cam_vsync rising edge in any state SHALL force IDLE and clear parity and the byte counter; the FIFO contents are kept.
REQ-021 Line parity SHALL be 0 on the first line of each frame.
REQ-022 The byte counter SHALL be 12 bits wide, increment on each valid camera byte in LINE, and saturate at 4095.
REQ-023 On a parity-0 (even) line, the block SHALL write every valid byte into the FIFO (2*LINE_PIXELS bytes).
REQ-024 On a parity-1 (odd) line, the block SHALL write only bytes with an even byte-counter value, i.e. Y bytes (LINE_PIXELS bytes); U and V bytes are discarded.
REQ-025 In LINE_END, if the byte counter is not equal to 2*LINE_PIXELS, line_err SHALL pulse for exactly one cycle.
REQ-026 Parity SHALL toggle regardless of any line error.
REQ-027 Valid camera bytes arriving outside LINE (in IDLE or WAIT_LINE) SHALL be ignored.
REQ-028 The FIFO SHALL be synchronous, FIFO_DEPTH x 8 bits, with read and write pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection.
REQ-029 w_valid SHALL equal FIFO not-empty, and data_o SHALL show the head entry with no extra register stage.
REQ-030 A pop SHALL occur when w_valid and w_ready are both 1.
REQ-031 data_o and w_valid SHALL remain stable while w_valid=1 and w_ready=0.
REQ-032 Simultaneous push and pop SHALL both take effect, including when the FIFO is full (the pop frees the slot) and when it is empty (w_valid rises the next cycle).
REQ-033 Latency SHALL be one cycle from a written camera byte to w_valid (with the FIFO empty and no backpressure).
REQ-034 A push when the FIFO is full without a simultaneous pop SHALL drop the byte and set overflow.
REQ-035 overflow SHALL clear only on reset or on the frame_start pulse.
REQ-036 The pointers SHALL wrap modulo 2*FIFO_DEPTH with no special-case logic.

Reset
REQ-037 On rst_n=0, asynchronously: state=IDLE, parity=0, byte counter=0, FIFO pointers=0.
REQ-038 On rst_n=0, asynchronously: w_valid=0, frame_start=0, line_err=0, overflow=0; data_o is don't-care while w_valid=0.
REQ-039 Reset asserted mid-line SHALL discard the FIFO contents; after release, no byte is accepted until the next cam_vsync falling edge.

Verification
REQ-040 Scenario (test parameter LINE_PIXELS=4): vsync fall, then line 0 with bytes 10..17 and line 1 with bytes 20..27, w_ready=1 -> output 10,11,...,17,20,22,24,26; frame_start pulses once; line_err never pulses.
REQ-041 Scenario: line 1 holds 7 bytes instead of 8 -> line_err pulses once in LINE_END; line 2 is still treated as even (all bytes kept).
REQ-042 Scenario (FIFO_DEPTH=16): w_ready=0 during a 20-byte even line -> first 16 bytes kept, overflow=1; after w_ready=1 exactly those 16 bytes are output in order; overflow clears at the next frame_start.
REQ-043 Scenario: FIFO full with w_ready=1 and a push in the same cycle -> no drop, count stays 16, overflow stays 0.
REQ-044 Scenario: cam_vsync rises mid-line 1 -> state IDLE; the next frame's first line is even and keeps U/V bytes.
REQ-045 Scenario: rst_n pulsed low mid-line -> all outputs 0 immediately; valid bytes before the next vsync fall are not output.
